pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage RV32I pipeline; drives the IF/ID/ID-EX pipeline-register controls.
//  Detects load-use hazards against the instruction being decoded, flushes wrong-path work on taken branches/jumps,
//  and freezes the whole pipeline while data memory is not ready, with a timeout trap.
//  Also keeps saturating stall/flush performance counters.
// PARAMETERS
//  REGFILE_ADDR_WIDTH  5   width of register addresses
//  CNT_WIDTH           32  width of Stall_count / Flush_count
//  MEM_TIMEOUT         16  consecutive MEM_WAIT cycles without Mem_ready before trap (>=1)
// PORTS
//  Clk            in   1    clock, all state on rising edge
//  Reset          in   1    asynchronous, active-high reset
//  Dec_Rs1_addr   in   RA   rs1 field of instruction in decode (from IF_Instruction)
//  Dec_Rs2_addr   in   RA   rs2 field of instruction in decode
//  Dec_Uses_rs1   in   1    decoded instruction reads rs1
//  Dec_Uses_rs2   in   1    decoded instruction reads rs2
//  EX_Rd_addr     in   RA   rd held in ID/EX register
//  EX_Mem_rd_en   in   1    ID/EX instruction is a load
//  EX_Redirect    in   1    branch taken or jump resolved in EX this cycle
//  Mem_req        in   1    MEM stage issuing a data access this cycle
//  Mem_ready      in   1    data memory completes the access this cycle
//  Cnt_clr        in   1    synchronous clear of both counters
//  IF_Stall       out  1    hold PC and IF/ID register
//  IF_Flush       out  1    squash IF/ID register to NOP
//  ID_Stall       out  1    hold ID/EX operands, force bubble (control signals zeroed)
//  ID_Flush       out  1    clear ID/EX register to NOP
//  Pipe_hold      out  1    freeze ID/EX, EX/MEM, MEM/WB registers (contents and control kept)
//  Mem_timeout    out  1    sticky trap: memory did not respond within MEM_TIMEOUT
//  Stall_count    out  CNT_WIDTH  cycles with IF_Stall=1
//  Flush_count    out  CNT_WIDTH  cycles with ID_Flush=1
// BEHAVIOUR
//  FSM states: RUN, MEM_WAIT, HALT. Reset -> RUN, wait_cnt=0, counters=0, Mem_timeout=0.
//  While Reset=1 every output is 0 regardless of inputs.
//  Hazard terms (combinational):
//    load_use = EX_Mem_rd_en & EX_Rd_addr!=0 &
//               ((Dec_Uses_rs1 & Dec_Rs1_addr==EX_Rd_addr) | (Dec_Uses_rs2 & Dec_Rs2_addr==EX_Rd_addr))
//    mem_busy = Mem_req & ~Mem_ready
//  Output priority per cycle: mem stall > redirect > load-use (mutually exclusive action).
//  RUN:
//    mem_busy          -> Pipe_hold=1, IF_Stall=1, others 0; next MEM_WAIT, wait_cnt<=0
//    else EX_Redirect  -> IF_Flush=1, ID_Flush=1; next RUN (a pending load_use is discarded)
//    else load_use     -> IF_Stall=1, ID_Stall=1 for exactly this cycle; next RUN
//    else              -> all outputs 0
//  MEM_WAIT:
//    Mem_ready=1       -> Pipe_hold=0, IF_Stall=0; EX_Redirect/load_use evaluated as in RUN this cycle; next RUN
//    Mem_ready=0       -> Pipe_hold=1, IF_Stall=1, flushes suppressed; wait_cnt+1;
//                         if wait_cnt==MEM_TIMEOUT-1 -> next HALT, Mem_timeout<=1
//  HALT: Pipe_hold=1, IF_Stall=1, all else 0; leaves only on Reset.
//  Outputs IF_Stall/IF_Flush/ID_Stall/ID_Flush/Pipe_hold are combinational (zero latency); Mem_timeout registered.
//  Counters: +1 on each qualifying cycle, saturate at all-ones, Cnt_clr wins over increment.
//  x0 never creates a hazard; rs1 and rs2 both matching still yields a single bubble.
//  Redirect during MEM_WAIT is not lost: EX is frozen, so it is acted on in the Mem_ready cycle.
// TESTING
//  1 EX_Mem_rd_en=1, EX_Rd_addr=5, Dec_Rs1_addr=5, Dec_Uses_rs1=1 -> IF_Stall=ID_Stall=1 one cycle; Stall_count 0->1
//  2 Same as 1 with EX_Rd_addr=0, Dec_Rs1_addr=0 -> no stall; Stall_count stays 0
//  3 EX_Redirect=1 together with load_use -> IF_Flush=ID_Flush=1, ID_Stall=0; Flush_count+1
//  4 Mem_req=1, Mem_ready low 3 cycles then high -> Pipe_hold=1 for 3 cycles, 0 in ready cycle; state RUN
//  5 MEM_TIMEOUT=4, Mem_ready never -> RUN hold cycle + 4 MEM_WAIT cycles, then Mem_timeout=1 sticky
//  6 Reset pulsed mid-MEM_WAIT (between edges) -> outputs 0 immediately; RUN, counters 0 after release

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the RV32I pipeline datapath and the stall/flush scheduler.
// The slave side is the scheduler; the master side is the pipeline (or a bench driving it).
interface pipeline_hazard_ctrl_if #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH          = 32
);
  logic [REGFILE_ADDR_WIDTH-1:0] Dec_Rs1_addr;
  logic [REGFILE_ADDR_WIDTH-1:0] Dec_Rs2_addr;
  logic                          Dec_Uses_rs1;
  logic                          Dec_Uses_rs2;
  logic [REGFILE_ADDR_WIDTH-1:0] EX_Rd_addr;
  logic                          EX_Mem_rd_en;
  logic                          EX_Redirect;
  logic                          Mem_req;
  logic                          Mem_ready;
  logic                          Cnt_clr;

  logic                          IF_Stall;
  logic                          IF_Flush;
  logic                          ID_Stall;
  logic                          ID_Flush;
  logic                          Pipe_hold;
  logic                          Mem_timeout;
  logic [CNT_WIDTH-1:0]          Stall_count;
  logic [CNT_WIDTH-1:0]          Flush_count;

  modport slave (
    input  Dec_Rs1_addr, Dec_Rs2_addr, Dec_Uses_rs1, Dec_Uses_rs2,
    input  EX_Rd_addr, EX_Mem_rd_en, EX_Redirect,
    input  Mem_req, Mem_ready, Cnt_clr,
    output IF_Stall, IF_Flush, ID_Stall, ID_Flush, Pipe_hold,
    output Mem_timeout, Stall_count, Flush_count
  );

  modport master (
    output Dec_Rs1_addr, Dec_Rs2_addr, Dec_Uses_rs1, Dec_Uses_rs2,
    output EX_Rd_addr, EX_Mem_rd_en, EX_Redirect,
    output Mem_req, Mem_ready, Cnt_clr,
    input  IF_Stall, IF_Flush, ID_Stall, ID_Flush, Pipe_hold,
    input  Mem_timeout, Stall_count, Flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage RV32I pipeline: load-use bubbles, redirect flushes,
// memory-wait freeze with a sticky timeout trap, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH          = 32,
  parameter int MEM_TIMEOUT        = 16
) (
  input  logic                     Clk,
  input  logic                     Reset,
  pipeline_hazard_ctrl_if.slave    hz
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t            state_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic              timeout_reg;

  logic [REGFILE_ADDR_WIDTH-1:0] rs1_addr;
  logic [REGFILE_ADDR_WIDTH-1:0] rs2_addr;
  logic [REGFILE_ADDR_WIDTH-1:0] rd_addr;

  logic load_use;
  logic mem_busy;
  logic if_stall;
  logic if_flush;
  logic id_stall;
  logic id_flush;
  logic pipe_hold;

  assign rs1_addr = hz.Dec_Rs1_addr;
  assign rs2_addr = hz.Dec_Rs2_addr;
  assign rd_addr  = hz.EX_Rd_addr;

  // x0 is hardwired zero, so a load targeting it can never feed the decoder.
  assign load_use = hz.EX_Mem_rd_en && (rd_addr != '0) &&
                    ((hz.Dec_Uses_rs1 && (rs1_addr == rd_addr)) ||
                     (hz.Dec_Uses_rs2 && (rs2_addr == rd_addr)));
  assign mem_busy = hz.Mem_req && !hz.Mem_ready;

  always_comb begin
    if_stall  = 1'b0;
    if_flush  = 1'b0;
    id_stall  = 1'b0;
    id_flush  = 1'b0;
    pipe_hold = 1'b0;
    if (!Reset) begin
      unique case (state_reg)
        RUN, MEM_WAIT: begin
          // In MEM_WAIT only Mem_ready releases the freeze; Mem_req is irrelevant there.
          if ((state_reg == RUN) ? mem_busy : !hz.Mem_ready) begin
            pipe_hold = 1'b1;
            if_stall  = 1'b1;
          end else if (hz.EX_Redirect) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
          end else if (load_use) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
          end
        end
        HALT: begin
          pipe_hold = 1'b1;
          if_stall  = 1'b1;
        end
        default: begin
          pipe_hold = 1'b1;
          if_stall  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      unique case (state_reg)
        RUN: begin
          if (mem_busy) begin
            state_reg    <= MEM_WAIT;
            wait_cnt_reg <= '0;
          end
        end
        MEM_WAIT: begin
          if (hz.Mem_ready) begin
            state_reg <= RUN;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
            if (wait_cnt_reg == WAIT_LAST) begin
              state_reg   <= HALT;
              timeout_reg <= 1'b1;
            end
          end
        end
        HALT: begin
          state_reg <= HALT;
        end
        default: begin
          state_reg <= HALT;
        end
      endcase
    end
  end

  // Counter 0 tracks IF_Stall cycles, counter 1 tracks ID_Flush cycles.
  logic [1:0] cnt_inc;
  assign cnt_inc = {id_flush, if_stall};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] cnt_reg;
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          cnt_reg <= '0;
        end else if (hz.Cnt_clr) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign hz.IF_Stall    = if_stall;
  assign hz.IF_Flush    = if_flush;
  assign hz.ID_Stall    = id_stall;
  assign hz.ID_Flush    = id_flush;
  assign hz.Pipe_hold   = pipe_hold;
  assign hz.Mem_timeout = timeout_reg;
  assign hz.Stall_count = g_cnt[0].cnt_reg;
  assign hz.Flush_count = g_cnt[1].cnt_reg;

endmodule
